sevenseg_scanner: RTL and testbench
===================================

Name: sevenseg_scanner

Overview:
Parametrised multi-digit seven-segment scan driver: time-multiplexes NUM_DIGITS hex digits onto a shared active-low segment bus with active-low digit selects. Next generation of the board display logic: adds per-digit enables, decimal points, leading-zero blanking, 16-level brightness PWM, anti-ghost guard interval and tear-free frame snapshotting. Sits between datapath debug values (state, direction, registers) and the board's display_sel/display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 2048, clock cycles each digit slot is held (>= GUARD+16)
GUARD, 16, blank cycles at start of every slot (>= 1)

Ports:
clock  input  1  system clock
Reset  input  1  asynchronous, active-high reset
digits  input  4*NUM_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i]; digit 0 rightmost
digit_en  input  NUM_DIGITS  1 = digit i may light
dp  input  NUM_DIGITS  1 = light decimal point of digit i
blank_lz  input  1  1 = blank leading zeros
brightness  input  4  0 = dimmest, 15 = full
display_sel  output  NUM_DIGITS  active-low digit select, one-hot-low or all ones
display  output  8  active-low segments, bit7 = dp, bits6..0 = g..a
frame_start  output  1  one-cycle pulse when snapshot loads

Behaviour:
- Reset (async, active-high): cnt=0, idx=0, snapshot regs=0, display_sel='1, display=8'hFF, frame_start=0.
- Slot counter cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and idx advances, idx wraps NUM_DIGITS-1 -> 0.
- Snapshot: in any cycle with cnt==0 && idx==0 (incl. first cycle after reset release), digits/digit_en/dp/blank_lz/brightness load into snapshot regs; frame_start registered high the following cycle. Mid-frame input changes have no visible effect until next frame.
- Decode (nibble -> bits6..0 with bit7=1): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E. dp set clears bit7.
- Leading-zero blank: with snapshot blank_lz=1, digit i blanked if all digits j>=i (j<NUM_DIGITS) are 0; digit 0 never blanked by this rule. dp of a blanked digit also off.
- on_time = ((brightness+1)*(SCAN_DIV-GUARD)) >> 4, computed at full width (no overflow).
- Lit condition for slot: GUARD <= cnt < GUARD+on_time AND digit_en[idx] AND not LZ-blanked.
- Outputs registered, 1-cycle latency from (cnt, idx, snapshot): lit -> display_sel = ~(1<<idx), display = decode; else display_sel='1, display=8'hFF.
- Never two selects low at once; select and segments change in the same edge; guard ensures >= GUARD cycles all-off between digits.
- Reset asserted mid-slot: outputs go blank immediately (async), scan restarts at idx 0 with fresh snapshot.

Decomposition:
- Package sevenseg_pkg: SEG_BLANK = 8'hFF, 16-entry segment constant table, function hex_to_seg(nibble, dp) -> 8 bits.
- Sub-module scan_timer: owns cnt, idx, frame_start generation; scanner keeps snapshot, blanking, PWM compare, output regs.

Test Plan:
(NUM_DIGITS=4, SCAN_DIV=32, GUARD=2 throughout)
- Reset release, digits=16'h12A0, all en, brightness=15 -> slot idx0: cycles cnt 2..31 show sel=1110, display=C0 (1-cycle lag); idx1 sel=1101 display=88; idx2 1011/A4; idx3 0111/F9; cnt 0..1 of each slot sel=1111 display=FF.
- brightness=0 -> exactly 1 lit cycle per slot (cnt==2); brightness=7 -> 15 lit cycles (cnt 2..16).
- digits=16'h0050, blank_lz=1 -> digits 3,2 never selected, digit1 shows 92, digit0 C0; digits=16'h0000 -> only digit 0 lit with C0.
- digit_en=4'b1011, dp=4'b0001 -> slot 2 fully blank; digit 0 display bit7=0 (e.g. 0 -> 40).
- Change digits mid-frame (idx=2) -> no change until next cnt==0&&idx==0; frame_start pulses once per 128 cycles.
- Assert Reset at idx=1, cnt=10 -> same cycle display_sel=1111, display=FF; after release scan restarts at idx0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and decode helper for the seven-segment scan driver.
package sevenseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns with dp off, indexed by hex nibble (entry 0 is the LSB slice).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Per-frame scalar settings captured alongside the digit snapshot.
  typedef struct packed {
    logic       blank_lz;
    logic [3:0] brightness;
  } frame_cfg_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp_on);
    logic [7:0] seg;
    seg    = SEG_TABLE[nibble];
    seg[7] = ~dp_on;
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scanner_if.sv
// Display-side bundle: debug values in, multiplexed select/segment pins out.
interface sevenseg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    blank_lz;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   display_sel;
  logic [7:0]              display;
  logic                    frame_start;

  modport master (
    output digits, digit_en, dp, blank_lz, brightness,
    input  display_sel, display, frame_start
  );

  modport slave (
    input  digits, digit_en, dp, blank_lz, brightness,
    output display_sel, display, frame_start
  );

endinterface

// File: rtl/sevenseg_scanner_scan_timer.sv
// Slot timer: cycle counter within a digit slot, current digit index, frame pulse.
module scan_timer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 2048
) (
  input  logic                          clock,
  input  logic                          Reset,
  output logic [$clog2(SCAN_DIV)-1:0]   cnt,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          frame_start,
  output logic                          frame_load_c
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  assign frame_load_c = (cnt == '0) && (idx == '0);

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_load_c;
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        if (idx == IW'(NUM_DIGITS - 1)) idx <= '0;
        else                            idx <= idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Multi-digit seven-segment scanner with frame snapshot, leading-zero blanking,
// brightness PWM and a blank guard at the start of every digit slot.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 2048,
  parameter int unsigned GUARD      = 16
) (
  input  logic               clock,
  input  logic               Reset,
  sevenseg_scanner_if.slave  bus
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = CW + 5;
  localparam int unsigned DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  frame_start;
  logic                  frame_load_c;

  logic [DW-1:0]         snap_digits;
  logic [NUM_DIGITS-1:0] snap_en;
  logic [NUM_DIGITS-1:0] snap_dp;
  frame_cfg_t            snap_cfg;

  logic [NUM_DIGITS-1:0] lz_c;
  logic                  zero_above;
  logic [3:0]            nib_c;
  logic [PW-1:0]         on_time_c;
  logic [PW-1:0]         cnt_w_c;
  logic                  lit_c;
  logic [7:0]            seg_c;

  logic [NUM_DIGITS-1:0] display_sel;
  logic [7:0]            display;

  scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_timer (
    .clock        (clock),
    .Reset        (Reset),
    .cnt          (cnt),
    .idx          (idx),
    .frame_start  (frame_start),
    .frame_load_c (frame_load_c)
  );

  // Inputs are frozen once per frame so a value never tears across digits.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      snap_digits <= '0;
      snap_en     <= '0;
      snap_dp     <= '0;
      snap_cfg    <= '0;
    end else if (frame_load_c) begin
      snap_digits         <= bus.digits;
      snap_en             <= bus.digit_en;
      snap_dp             <= bus.dp;
      snap_cfg.blank_lz   <= bus.blank_lz;
      snap_cfg.brightness <= bus.brightness;
    end
  end

  // Digit i is a leading zero when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    lz_c       = '0;
    zero_above = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (snap_digits[4*i +: 4] == 4'h0);
      if (i != 0) lz_c[i] = zero_above & snap_cfg.blank_lz;
    end
  end

  // Lit window starts after the guard; its length scales with brightness in 1/16 steps.
  always_comb begin
    nib_c     = snap_digits[{idx, 2'b00} +: 4];
    on_time_c = PW'(((PW'(snap_cfg.brightness) + PW'(1)) * PW'(SCAN_DIV - GUARD)) >> 4);
    cnt_w_c   = PW'(cnt);
    lit_c     = (cnt_w_c >= PW'(GUARD)) &&
                (cnt_w_c < (PW'(GUARD) + on_time_c)) &&
                snap_en[idx] && !lz_c[idx];
    seg_c     = hex_to_seg(nib_c, snap_dp[idx]);
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      display_sel <= '1;
      display     <= SEG_BLANK;
    end else if (lit_c) begin
      display_sel <= ~(NUM_DIGITS'(1) << idx);
      display     <= seg_c;
    end else begin
      display_sel <= '1;
      display     <= SEG_BLANK;
    end
  end

  assign bus.display_sel = display_sel;
  assign bus.display     = display;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner (4 digits, 32-cycle slots, 2-cycle guard).
module tb_sevenseg_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned SDIV  = 32;
  localparam int unsigned GRD   = 2;
  localparam int          FRAME = 128;
  localparam int          NVEC  = 14;

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      en;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0]      bright;
    logic [5:0]      lit_n;
    logic [3:0][7:0] seg;        // expected pattern per slot, FF = slot stays dark
    logic            mid_en;
    logic [15:0]     mid_digits;
  } vec_t;

  logic clock;
  logic Reset;
  int   n_cmp;
  int   n_bad;
  int   cur_vec;
  int   waited;
  vec_t vecs [NVEC];

  sevenseg_scanner_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SDIV),
    .GUARD      (GRD)
  ) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp,
                              input logic blz, input logic [3:0] br, input logic [5:0] lit_n,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input logic mid_en, input logic [15:0] mid_d);
    vec_t v;
    v.digits = d;   v.en = en;   v.dp = dp;   v.blz = blz;   v.bright = br;
    v.lit_n  = lit_n;
    v.seg[0] = s0;  v.seg[1] = s1;  v.seg[2] = s2;  v.seg[3] = s3;
    v.mid_en = mid_en;  v.mid_digits = mid_d;
    return v;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d k=%0d: got %0h expected %0h", name, cur_vec, k, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.digits     = v.digits;
    bus.digit_en   = v.en;
    bus.dp         = v.dp;
    bus.blank_lz   = v.blz;
    bus.brightness = v.bright;
  endtask

  // Advance on negedges until frame_start is seen; leaves us in frame cycle 1.
  task automatic wait_frame(output int n);
    logic found;
    found = 1'b0;
    n     = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clock);
      n++;
      if (bus.frame_start) found = 1'b1;
    end
    check("frame_start_seen", n, 32'(found), 32'd1);
  endtask

  // Frame cycle k shows the decision made at cycle k-1 (slot (k-1)/32, count (k-1)%32).
  task automatic observe(input vec_t v);
    int fs_cnt;
    fs_cnt = 0;
    for (int k = 1; k <= FRAME; k++) begin
      int         s;
      int         c;
      logic       exp_lit;
      logic [3:0] esel;
      logic [7:0] eseg;
      if (k > 1) @(negedge clock);
      if (v.mid_en && k == 70) bus.digits = v.mid_digits;
      s       = (k - 1) / 32;
      c       = (k - 1) % 32;
      exp_lit = (v.seg[s] != 8'hFF) && (c >= 2) && (c < 2 + int'(v.lit_n));
      esel    = exp_lit ? ~(4'b0001 << s) : 4'hF;
      eseg    = exp_lit ? v.seg[s] : 8'hFF;
      check("display_sel", k, 32'(bus.display_sel), 32'(esel));
      check("display", k, 32'(bus.display), 32'(eseg));
      if (bus.frame_start) fs_cnt++;
    end
    check("frame_start_per_frame", FRAME, 32'(fs_cnt), 32'd1);
  endtask

  initial begin
    clock = 1'b0;
    Reset = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    cur_vec = -1;
    bus.digits = '0;  bus.digit_en = '0;  bus.dp = '0;
    bus.blank_lz = 1'b0;  bus.brightness = '0;

    vecs[0]  = mk(16'h12A0, 4'hF, 4'h0, 1'b0, 4'd15, 6'd30, 8'hC0, 8'h88, 8'hA4, 8'hF9, 1'b1, 16'h5555);
    vecs[1]  = mk(16'h5555, 4'hF, 4'h0, 1'b0, 4'd15, 6'd30, 8'h92, 8'h92, 8'h92, 8'h92, 1'b0, 16'h0);
    vecs[2]  = mk(16'h12A0, 4'hF, 4'h0, 1'b0, 4'd0,  6'd1,  8'hC0, 8'h88, 8'hA4, 8'hF9, 1'b0, 16'h0);
    vecs[3]  = mk(16'h12A0, 4'hF, 4'h0, 1'b0, 4'd7,  6'd15, 8'hC0, 8'h88, 8'hA4, 8'hF9, 1'b0, 16'h0);
    vecs[4]  = mk(16'h0050, 4'hF, 4'h0, 1'b1, 4'd15, 6'd30, 8'hC0, 8'h92, 8'hFF, 8'hFF, 1'b0, 16'h0);
    vecs[5]  = mk(16'h0000, 4'hF, 4'h0, 1'b1, 4'd15, 6'd30, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0);
    vecs[6]  = mk(16'h12A0, 4'hB, 4'h1, 1'b0, 4'd15, 6'd30, 8'h40, 8'h88, 8'hFF, 8'hF9, 1'b0, 16'h0);
    vecs[7]  = mk(16'h0050, 4'hF, 4'hE, 1'b1, 4'd15, 6'd30, 8'hC0, 8'h12, 8'hFF, 8'hFF, 1'b0, 16'h0);
    vecs[8]  = mk(16'h3456, 4'hF, 4'h0, 1'b0, 4'd15, 6'd30, 8'h82, 8'h92, 8'h99, 8'hB0, 1'b0, 16'h0);
    vecs[9]  = mk(16'h789F, 4'hF, 4'h0, 1'b0, 4'd15, 6'd30, 8'h8E, 8'h90, 8'h80, 8'hF8, 1'b0, 16'h0);
    vecs[10] = mk(16'hBCDE, 4'hF, 4'h0, 1'b0, 4'd15, 6'd30, 8'h86, 8'hA1, 8'hC6, 8'h83, 1'b0, 16'h0);
    vecs[11] = mk(16'h0100, 4'hF, 4'h0, 1'b1, 4'd15, 6'd30, 8'hC0, 8'hC0, 8'hF9, 8'hFF, 1'b0, 16'h0);
    vecs[12] = mk(16'h0050, 4'hF, 4'h0, 1'b0, 4'd15, 6'd30, 8'hC0, 8'h92, 8'hC0, 8'hC0, 1'b0, 16'h0);
    vecs[13] = mk(16'h12A0, 4'h0, 4'hF, 1'b0, 4'd15, 6'd30, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0);

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_sel", 0, 32'(bus.display_sel), 32'hF);
    check("reset_display", 0, 32'(bus.display), 32'hFF);
    check("reset_frame_start", 0, 32'(bus.frame_start), 32'h0);

    // First frame loads on the very first cycle after release
    cur_vec = 0;
    apply(vecs[0]);
    Reset = 1'b0;
    wait_frame(waited);
    check("first_frame_latency", 0, 32'(waited), 32'd1);
    observe(vecs[0]);

    for (int i = 1; i < NVEC; i++) begin
      cur_vec = i;
      apply(vecs[i]);
      wait_frame(waited);
      if (i == 1) check("next_frame_latency", 0, 32'(waited), 32'd1);
      observe(vecs[i]);
    end

    // Reset in the middle of slot 1 (cnt 10): immediate blank, then restart at digit 0
    cur_vec = 100;
    apply(vecs[3]);
    wait_frame(waited);
    repeat (41) @(negedge clock);
    check("pre_reset_sel", 42, 32'(bus.display_sel), 32'hD);
    check("pre_reset_display", 42, 32'(bus.display), 32'h88);
    Reset = 1'b1;
    #1;
    check("async_reset_sel", 42, 32'(bus.display_sel), 32'hF);
    check("async_reset_display", 42, 32'(bus.display), 32'hFF);
    check("async_reset_frame_start", 42, 32'(bus.frame_start), 32'h0);
    @(negedge clock);
    Reset = 1'b0;
    wait_frame(waited);
    check("restart_latency", 0, 32'(waited), 32'd1);
    observe(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
